decode_pipe: RTL and testbench

Parametrised, pipelined decode stage for the 16-bit ISA core.
- Reads two source registers from an internal register file with write-back bypass.
- Builds the immediate and the two PC targets (branch and jump).
- Latches all results into a registered ID/EX output slot with valid/ready handshakes.
- Adds load-use stall detection and a pipeline flush.
- Width and register count are generalised by parameters.

---
 rtl/decode_pkg.sv | 18 +
 rtl/regfile_bypass_p.sv | 36 +++
 rtl/decode_pipe.sv | 116 +++++++++++
 tb/tb_decode_pipe.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared constants for the decode stage: destination-select encodings,
// immediate field widths and the register-select width helper.
package decode_pkg;

    localparam logic [1:0] REG_DST_RD   = 2'b00;
    localparam logic [1:0] REG_DST_RT   = 2'b01;
    localparam logic [1:0] REG_DST_RS   = 2'b10;
    localparam logic [1:0] REG_DST_LAST = 2'b11;

    localparam int I5_W  = 5;
    localparam int I8_W  = 8;
    localparam int J11_W = 11;

    function automatic int reg_sel_w(input int num_regs);
        return $clog2(num_regs);
    endfunction

endpackage

// File: rtl/regfile_bypass_p.sv
// Register file with two combinational read ports; a same-cycle write to the
// selected register is forwarded to the read data (write-first).
module regfile_bypass_p
    import decode_pkg::*;
#(
    parameter int  DATA_W    = 16,
    parameter int  NUM_REGS  = 8,
    localparam int REG_SEL_W = reg_sel_w(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_en,
    input  logic [REG_SEL_W-1:0] wb_sel,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic [REG_SEL_W-1:0] rs_sel,
    input  logic [REG_SEL_W-1:0] rt_sel,
    output logic [DATA_W-1:0]    rs_data,
    output logic [DATA_W-1:0]    rt_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_sel] <= wb_data;
        end
    end

    assign rs_data = (wb_en && (wb_sel == rs_sel)) ? wb_data : regs[rs_sel];
    assign rt_data = (wb_en && (wb_sel == rt_sel)) ? wb_data : regs[rt_sel];

endmodule

// File: rtl/decode_pipe.sv
// Pipelined decode stage: register read with bypass, immediate and PC-target
// generation, load-use stall and flush, latched into a handshaked ID/EX slot.
module decode_pipe
    import decode_pkg::*;
#(
    parameter int  DATA_W    = 16,
    parameter int  NUM_REGS  = 8,
    localparam int REG_SEL_W = reg_sel_w(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          instruction,
    input  logic [DATA_W-1:0]    pc_2,
    input  logic [1:0]           reg_dst,
    input  logic                 is_jal,
    input  logic                 sign_ext,
    input  logic                 immd_src,
    input  logic                 mem_read,
    input  logic                 flush,
    input  logic                 wb_en,
    input  logic [REG_SEL_W-1:0] wb_sel,
    input  logic [DATA_W-1:0]    wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_rd1,
    output logic [DATA_W-1:0]    out_rd2,
    output logic [DATA_W-1:0]    out_immd,
    output logic [DATA_W-1:0]    out_pc_br,
    output logic [DATA_W-1:0]    out_pc_jmp,
    output logic [REG_SEL_W-1:0] out_wsel,
    output logic                 out_mem_read,
    output logic                 err
);

    logic [REG_SEL_W-1:0] rs, rt, rd, wsel;
    logic [DATA_W-1:0]    rd1, rd2, i5_ext, i8_ext, j11_ext;
    logic                 hazard, accept;
    logic                 unused_opcode;

    assign rs = REG_SEL_W'(instruction[10:8]);
    assign rt = REG_SEL_W'(instruction[7:5]);
    assign rd = REG_SEL_W'(instruction[4:2]);
    assign unused_opcode = ^instruction[15:11];

    regfile_bypass_p #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wb_en   (wb_en),
        .wb_sel  (wb_sel),
        .wb_data (wb_data),
        .rs_sel  (rs),
        .rt_sel  (rt),
        .rs_data (rd1),
        .rt_data (rd2)
    );

    assign i5_ext  = {{(DATA_W-I5_W){sign_ext & instruction[I5_W-1]}}, instruction[I5_W-1:0]};
    assign i8_ext  = {{(DATA_W-I8_W){sign_ext & instruction[I8_W-1]}}, instruction[I8_W-1:0]};
    assign j11_ext = {{(DATA_W-J11_W){instruction[J11_W-1]}}, instruction[J11_W-1:0]};

    always_comb begin
        wsel = rd;
        case (reg_dst)
            REG_DST_RD:   wsel = rd;
            REG_DST_RT:   wsel = rt;
            REG_DST_RS:   wsel = rs;
            REG_DST_LAST: wsel = REG_SEL_W'(NUM_REGS - 1);
        endcase
    end

    // rt is compared even for formats that do not read it: a rare extra stall is harmless
    assign hazard   = out_valid & out_mem_read & ((out_wsel == rs) | (out_wsel == rt));
    assign in_ready = flush | ((~out_valid | out_ready) & ~hazard);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            out_rd1      <= '0;
            out_rd2      <= '0;
            out_immd     <= '0;
            out_pc_br    <= '0;
            out_pc_jmp   <= '0;
            out_wsel     <= '0;
            out_mem_read <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_rd1      <= rd1;
            out_rd2      <= rd2;
            out_immd     <= immd_src ? i5_ext : i8_ext;
            out_pc_br    <= pc_2 + i8_ext;
            out_pc_jmp   <= pc_2 + j11_ext;
            out_wsel     <= wsel;
            out_mem_read <= mem_read;
        end else if (out_ready) begin
            // A hazard always blocks accept, so this branch also inserts the load-use bubble
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (accept && !flush && (reg_dst == REG_DST_LAST) && !is_jal) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe (DATA_W=16, NUM_REGS=16) against a
// cycle-level behavioural model of the decode stage.
module tb_decode_pipe;

    localparam int DW = 16;
    localparam int NR = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid, in_ready;
    logic [15:0]   instruction;
    logic [DW-1:0] pc_2;
    logic [1:0]    reg_dst;
    logic          is_jal, sign_ext, immd_src, mem_read, flush;
    logic          wb_en;
    logic [SW-1:0] wb_sel;
    logic [DW-1:0] wb_data;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_rd1, out_rd2, out_immd, out_pc_br, out_pc_jmp;
    logic [SW-1:0] out_wsel;
    logic          out_mem_read, err;

    int checks = 0;
    int errors = 0;

    // model state
    logic [DW-1:0] mreg [NR];
    logic          m_valid, m_mr, m_err;
    logic [DW-1:0] m_rd1, m_rd2, m_immd, m_br, m_jmp;
    logic [SW-1:0] m_wsel;

    decode_pipe #(.DATA_W(DW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc_2(pc_2), .reg_dst(reg_dst), .is_jal(is_jal),
        .sign_ext(sign_ext), .immd_src(immd_src), .mem_read(mem_read), .flush(flush),
        .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd1(out_rd1), .out_rd2(out_rd2), .out_immd(out_immd),
        .out_pc_br(out_pc_br), .out_pc_jmp(out_pc_jmp), .out_wsel(out_wsel),
        .out_mem_read(out_mem_read), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ext(input int v, input int bits, input logic sgn);
        int x;
        x = v;
        if (sgn && x >= (1 << (bits - 1))) x = x - (1 << bits);
        return DW'(x);
    endfunction

    function automatic logic m_hazard();
        int rs, rt;
        rs = int'(instruction[10:8]);
        rt = int'(instruction[7:5]);
        return m_valid && m_mr && (int'(m_wsel) == rs || int'(m_wsel) == rt);
    endfunction

    function automatic logic m_in_ready();
        return flush || ((!m_valid || out_ready) && !m_hazard());
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) mreg[i] = '0;
        m_valid = 0; m_mr = 0; m_err = 0;
        m_rd1 = '0; m_rd2 = '0; m_immd = '0; m_br = '0; m_jmp = '0; m_wsel = '0;
    endtask

    task automatic set_idle();
        in_valid = 0; instruction = '0; pc_2 = '0; reg_dst = 2'b00; is_jal = 0;
        sign_ext = 0; immd_src = 0; mem_read = 0; flush = 0;
        wb_en = 0; wb_sel = '0; wb_data = '0; out_ready = 1;
    endtask

    // Advances one clock and moves the model by the same edge; no comparisons here.
    task automatic clk_step();
        logic          acc;
        int            rs, rt;
        logic [DW-1:0] n_rd1, n_rd2, i5, i8, j11;
        logic [SW-1:0] n_wsel;
        acc = in_valid && m_in_ready();
        rs = int'(instruction[10:8]);
        rt = int'(instruction[7:5]);
        n_rd1 = (wb_en && int'(wb_sel) == rs) ? wb_data : mreg[rs];
        n_rd2 = (wb_en && int'(wb_sel) == rt) ? wb_data : mreg[rt];
        i5  = ext(int'(instruction[4:0]), 5, sign_ext);
        i8  = ext(int'(instruction[7:0]), 8, sign_ext);
        j11 = ext(int'(instruction[10:0]), 11, 1'b1);
        case (reg_dst)
            2'd0:    n_wsel = SW'(instruction[4:2]);
            2'd1:    n_wsel = SW'(instruction[7:5]);
            2'd2:    n_wsel = SW'(instruction[10:8]);
            default: n_wsel = SW'(NR - 1);
        endcase
        @(posedge clk);
        #1;
        if (flush) begin
            m_valid = 0;
        end else if (acc) begin
            m_valid = 1;
            m_rd1 = n_rd1; m_rd2 = n_rd2;
            m_immd = immd_src ? i5 : i8;
            m_br  = DW'(int'(pc_2) + int'(i8));
            m_jmp = DW'(int'(pc_2) + int'(j11));
            m_wsel = n_wsel;
            m_mr = mem_read;
            if (reg_dst == 2'b11 && !is_jal) m_err = 1;
        end else if (out_ready) begin
            m_valid = 0;
        end
        if (wb_en) mreg[wb_sel] = wb_data;
    endtask

    task automatic test_reset();
        set_idle();
        model_clear();
        rst = 0;
        #12;
        checks += 10;
        if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        if (out_rd1 !== 16'h0)    begin errors++; $display("FAIL reset_rd1: got %h expected 0", out_rd1); end
        if (out_rd2 !== 16'h0)    begin errors++; $display("FAIL reset_rd2: got %h expected 0", out_rd2); end
        if (out_immd !== 16'h0)   begin errors++; $display("FAIL reset_immd: got %h expected 0", out_immd); end
        if (out_pc_br !== 16'h0)  begin errors++; $display("FAIL reset_pc_br: got %h expected 0", out_pc_br); end
        if (out_pc_jmp !== 16'h0) begin errors++; $display("FAIL reset_pc_jmp: got %h expected 0", out_pc_jmp); end
        if (out_wsel !== 4'h0)    begin errors++; $display("FAIL reset_wsel: got %h expected 0", out_wsel); end
        if (out_mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b expected 0", out_mem_read); end
        if (err !== 1'b0)         begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        set_idle();
        instruction = 16'h03A0;   // rs=3 rt=5
        in_valid = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b expected 1", in_ready); end
        clk_step();
        checks += 4;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
        if (out_rd1 !== 16'h0)  begin errors++; $display("FAIL basic_rd1: got %h expected 0", out_rd1); end
        if (out_rd2 !== 16'h0)  begin errors++; $display("FAIL basic_rd2: got %h expected 0", out_rd2); end
        if (err !== 1'b0)       begin errors++; $display("FAIL basic_err: got %b expected 0", err); end
        in_valid = 0;
        clk_step();
    endtask

    task automatic test_bypass();
        set_idle();
        instruction = 16'h0200;   // rs=2 rt=0
        wb_en = 1; wb_sel = 4'd2; wb_data = 16'hBEEF;
        in_valid = 1;
        clk_step();
        checks += 2;
        if (out_rd1 !== 16'hBEEF) begin errors++; $display("FAIL bypass_rd1: got %h expected beef", out_rd1); end
        if (out_rd2 !== 16'h0)    begin errors++; $display("FAIL bypass_rd2: got %h expected 0", out_rd2); end
        wb_en = 0;
        instruction = 16'h0240;   // rs=2 rt=2, now from storage
        clk_step();
        checks += 2;
        if (out_rd1 !== 16'hBEEF) begin errors++; $display("FAIL stored_rd1: got %h expected beef", out_rd1); end
        if (out_rd2 !== 16'hBEEF) begin errors++; $display("FAIL stored_rd2: got %h expected beef", out_rd2); end
        in_valid = 0;
        clk_step();
    endtask

    task automatic test_pc();
        set_idle();
        in_valid = 1; pc_2 = 16'h0010; sign_ext = 1;
        instruction = 16'h00FE;
        clk_step();
        checks += 3;
        if (out_pc_br !== 16'h000E)  begin errors++; $display("FAIL pc_br_neg: got %h expected 000e", out_pc_br); end
        if (out_immd !== 16'hFFFE)   begin errors++; $display("FAIL immd_i8_sext: got %h expected fffe", out_immd); end
        if (out_pc_jmp !== 16'h010E) begin errors++; $display("FAIL pc_jmp_pos: got %h expected 010e", out_pc_jmp); end
        instruction = 16'h0400;
        clk_step();
        checks += 2;
        if (out_pc_jmp !== 16'hFC10) begin errors++; $display("FAIL pc_jmp_neg: got %h expected fc10", out_pc_jmp); end
        if (out_pc_br !== 16'h0010)  begin errors++; $display("FAIL pc_br_zero: got %h expected 0010", out_pc_br); end
        instruction = 16'h00FE; sign_ext = 0;
        clk_step();
        checks++;
        if (out_pc_br !== 16'h010E) begin errors++; $display("FAIL pc_br_zext: got %h expected 010e", out_pc_br); end
        instruction = 16'h0010; immd_src = 1; sign_ext = 1;
        clk_step();
        checks++;
        if (out_immd !== 16'hFFF0) begin errors++; $display("FAIL immd_i5_sext: got %h expected fff0", out_immd); end
        sign_ext = 0;
        clk_step();
        checks++;
        if (out_immd !== 16'h0010) begin errors++; $display("FAIL immd_i5_zext: got %h expected 0010", out_immd); end
        instruction = 16'h0004; immd_src = 0; pc_2 = 16'hFFFE;
        clk_step();
        checks++;
        if (out_pc_br !== 16'h0002) begin errors++; $display("FAIL pc_br_wrap: got %h expected 0002", out_pc_br); end
        in_valid = 0;
        clk_step();
    endtask

    task automatic test_hazard();
        set_idle();
        in_valid = 1; instruction = 16'h0010; mem_read = 1;   // load to r4
        clk_step();
        checks += 3;
        if (out_valid !== 1'b1)    begin errors++; $display("FAIL load_valid: got %b expected 1", out_valid); end
        if (out_wsel !== 4'd4)     begin errors++; $display("FAIL load_wsel: got %h expected 4", out_wsel); end
        if (out_mem_read !== 1'b1) begin errors++; $display("FAIL load_mem_read: got %b expected 1", out_mem_read); end
        instruction = 16'h0400; mem_read = 0;   // rs=4
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_rs_ready: got %b expected 0", in_ready); end
        clk_step();
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL hazard_bubble: got %b expected 0", out_valid); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL hazard_release: got %b expected 1", in_ready); end
        clk_step();
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL hazard_accept: got %b expected 1", out_valid); end
        if (out_mem_read !== 1'b0) begin errors++; $display("FAIL hazard_next_mr: got %b expected 0", out_mem_read); end
        instruction = 16'h0010; mem_read = 1;
        clk_step();
        instruction = 16'h0080; mem_read = 0;   // rt=4
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_rt_ready: got %b expected 0", in_ready); end
        clk_step();
        clk_step();
        in_valid = 0;
        clk_step();
    endtask

    task automatic test_flush();
        set_idle();
        in_valid = 1; instruction = 16'h0010; mem_read = 1;
        clk_step();
        instruction = 16'h0400; mem_read = 0; flush = 1;
        reg_dst = 2'b11; is_jal = 0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", in_ready); end
        clk_step();
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        if (err !== 1'b0)       begin errors++; $display("FAIL flush_err: got %b expected 0", err); end
        set_idle();
        clk_step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] h_rd1, h_immd, h_br, h_jmp;
        logic [SW-1:0] h_wsel;
        set_idle();
        in_valid = 1; instruction = 16'h1234; pc_2 = 16'h0100; sign_ext = 1;
        clk_step();
        h_rd1 = out_rd1; h_immd = out_immd; h_br = out_pc_br; h_jmp = out_pc_jmp; h_wsel = out_wsel;
        checks++;
        if (h_br !== m_br) begin errors++; $display("FAIL bp_first_br: got %h expected %h", h_br, m_br); end
        out_ready = 0; instruction = 16'h0567; pc_2 = 16'h0200;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
            clk_step();
            checks += 2;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
            if (out_rd1 !== h_rd1 || out_immd !== h_immd || out_pc_br !== h_br ||
                out_pc_jmp !== h_jmp || out_wsel !== h_wsel) begin
                errors++;
                $display("FAIL bp_hold: got %h %h %h %h %h expected %h %h %h %h %h",
                         out_rd1, out_immd, out_pc_br, out_pc_jmp, out_wsel,
                         h_rd1, h_immd, h_br, h_jmp, h_wsel);
            end
        end
        out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b expected 1", in_ready); end
        clk_step();
        checks += 2;
        if (out_pc_br !== m_br)   begin errors++; $display("FAIL bp_next_br: got %h expected %h", out_pc_br, m_br); end
        if (out_pc_jmp !== m_jmp) begin errors++; $display("FAIL bp_next_jmp: got %h expected %h", out_pc_jmp, m_jmp); end
        in_valid = 0;
        clk_step();
    endtask

    task automatic test_jal_wsel();
        set_idle();
        in_valid = 1; reg_dst = 2'b11; is_jal = 1; instruction = 16'h0714;
        clk_step();
        checks += 2;
        if (out_wsel !== 4'd15) begin errors++; $display("FAIL jal_wsel: got %h expected f", out_wsel); end
        if (err !== 1'b0)       begin errors++; $display("FAIL jal_err: got %b expected 0", err); end
        reg_dst = 2'b01;
        clk_step();
        checks++;
        if (out_wsel !== 4'd0) begin errors++; $display("FAIL rt_wsel: got %h expected 0", out_wsel); end
        reg_dst = 2'b10;
        clk_step();
        checks++;
        if (out_wsel !== 4'd7) begin errors++; $display("FAIL rs_wsel: got %h expected 7", out_wsel); end
        in_valid = 0;
        clk_step();
    endtask

    task automatic test_err();
        set_idle();
        in_valid = 1; reg_dst = 2'b11; is_jal = 0;
        clk_step();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", err); end
        set_idle();
        for (int k = 0; k < 3; k++) begin
            clk_step();
            checks++;
            if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
        end
        in_valid = 1; out_ready = 0;
        clk_step();
        #2;
        rst = 0;
        #1;
        model_clear();
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", out_valid); end
        if (err !== 1'b0)       begin errors++; $display("FAIL midreset_err: got %b expected 0", err); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL midreset_ready: got %b expected 1", in_ready); end
        set_idle();
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            in_valid    = ($urandom % 4) != 0;
            instruction = 16'($urandom);
            pc_2        = 16'($urandom);
            reg_dst     = 2'($urandom % 4);
            is_jal      = 1'($urandom);
            sign_ext    = 1'($urandom);
            immd_src    = 1'($urandom);
            mem_read    = ($urandom % 3) == 0;
            flush       = ($urandom % 10) == 0;
            wb_en       = 1'($urandom);
            wb_sel      = 4'($urandom % 8);
            wb_data     = 16'($urandom);
            out_ready   = ($urandom % 4) != 0;
            #1;
            checks++;
            if (in_ready !== m_in_ready()) begin
                errors++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", n, in_ready, m_in_ready());
            end
            clk_step();
            checks += 2;
            if (out_valid !== m_valid) begin
                errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", n, out_valid, m_valid);
            end
            if (err !== m_err) begin
                errors++; $display("FAIL rnd_err[%0d]: got %b expected %b", n, err, m_err);
            end
            if (m_valid) begin
                checks++;
                if (out_rd1 !== m_rd1 || out_rd2 !== m_rd2 || out_immd !== m_immd ||
                    out_pc_br !== m_br || out_pc_jmp !== m_jmp || out_wsel !== m_wsel ||
                    out_mem_read !== m_mr) begin
                    errors++;
                    $display("FAIL rnd_slot[%0d]: got %h %h %h %h %h %h %b expected %h %h %h %h %h %h %b", n,
                             out_rd1, out_rd2, out_immd, out_pc_br, out_pc_jmp, out_wsel, out_mem_read,
                             m_rd1, m_rd2, m_immd, m_br, m_jmp, m_wsel, m_mr);
                end
            end
        end
        set_idle();
        clk_step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_pc();
        test_hazard();
        test_flush();
        test_backpressure();
        test_jal_wsel();
        test_err();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
